// File: rtl/tile_skew_feeder_if.sv
// Producer-side row handshake for the tile skew feeder.
// The producer drives in_valid/in_row and the feeder answers with in_ready.
interface tile_skew_feeder_if #(
  parameter int N = 8,
  parameter int W = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_row;

  modport master (output in_valid, output in_row, input in_ready);
  modport slave  (input in_valid, input in_row, output in_ready);
endinterface

// File: rtl/tile_skew_feeder.sv
// Tile skew feeder: gathers N-lane rows into two ping-pong tile banks and
// replays each complete tile as a gap-free stream in which lane i trails
// lane 0 by i cycles, with per-element clear and tile-done markers.
module tile_skew_feeder #(
  parameter int N = 8,
  parameter int W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  tile_skew_feeder_if.slave    prod,
  output logic [W-1:0]         x_out [N-1:0],
  output logic [N-1:0]         mult_clear,
  output logic [N-1:0]         lane_valid,
  output logic                 start,
  output logic                 tile_done
);

  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST = RW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t         state, next_state;
  logic [N*W-1:0] bank [2][N];
  logic [1:0]     full;
  logic [1:0]     set_full, clr_full;
  logic           wr_sel, rd_sel;
  logic [RW-1:0]  w, r;
  logic           accept, fill_last, drain_last;
  logic           rd_en;
  logic [RW-1:0]  rd_row;
  logic [N*W-1:0] rd_data;
  logic [N-1:0]   lane_last;

  assign prod.in_ready = enable && !reset && !full[wr_sel];
  assign accept        = prod.in_valid && prod.in_ready;
  assign fill_last     = accept && (w == LAST);
  assign drain_last    = enable && rd_en && (rd_row == LAST);
  assign rd_data       = bank[rd_sel][rd_row];

  // Tile storage: the accepted row lands in the bank currently being filled.
  always_ff @(posedge clk) begin
    if (accept) bank[wr_sel][w] <= prod.in_row;
  end

  // Fill pointer: row counter inside the tile and the bank being filled.
  always_ff @(posedge clk) begin
    if (reset) begin
      w      <= '0;
      wr_sel <= 1'b0;
    end else if (accept) begin
      if (w == LAST) begin
        w      <= '0;
        wr_sel <= ~wr_sel;
      end else begin
        w <= w + RW'(1);
      end
    end
  end

  // A bank is marked full by its last row and freed by its last read.
  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (fill_last)  set_full[wr_sel] = 1'b1;
    if (drain_last) clr_full[rd_sel] = 1'b1;
  end

  // Bank occupancy flags; fill and drain of different banks can coincide.
  always_ff @(posedge clk) begin
    if (reset) full <= '0;
    else       full <= (full & ~clr_full) | set_full;
  end

  // Drain state register.
  always_ff @(posedge clk) begin
    if (reset)       state <= IDLE;
    else if (enable) state <= next_state;
  end

  // Drain next state: stay streaming across tiles when the other bank waits.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (full[rd_sel]) next_state = STREAM;
      STREAM: if (r == LAST && !full[~rd_sel]) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Drain outputs: IDLE already reads row 0 so a fresh tile starts at once.
  always_comb begin
    rd_en  = 1'b0;
    rd_row = '0;
    case (state)
      IDLE: begin
        rd_en  = full[rd_sel];
        rd_row = '0;
      end
      STREAM: begin
        rd_en  = 1'b1;
        rd_row = r;
      end
      default: begin
        rd_en  = 1'b0;
        rd_row = '0;
      end
    endcase
  end

  // Read pointer: next row to read and the bank being drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      r      <= '0;
      rd_sel <= 1'b0;
    end else if (enable && rd_en) begin
      if (rd_row == LAST) begin
        r      <= '0;
        rd_sel <= ~rd_sel;
      end else begin
        r <= rd_row + RW'(1);
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    localparam int D = i + 1;
    logic [W+2:0] sr [D];
    logic [W+2:0] head;

    assign head = rd_en ? {rd_data[i*W +: W], 1'b1, (rd_row == '0),
                           ((i == N - 1) && (rd_row == LAST))} : '0;

    // Lane delay line: data, valid, clear and last bits shift together.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int k = 0; k < D; k++) sr[k] <= '0;
      end else if (enable) begin
        sr[0] <= head;
        for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
      end
    end

    assign x_out[i]      = sr[D-1][W+2:3];
    assign lane_valid[i] = sr[D-1][2];
    assign mult_clear[i] = sr[D-1][1];
    assign lane_last[i]  = sr[D-1][0];
  end

  assign start     = |lane_valid;
  assign tile_done = |(lane_last & lane_valid);

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Self-checking bench for tile_skew_feeder: directed tile sequences checked
// against a fixed expectation table, plus random traffic checked every cycle
// against a tile-timing reference model.
module tb_tile_skew_feeder;

  localparam int N    = 8;
  localparam int W    = 32;
  localparam int MAXT = 512;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] x_out [N-1:0];
  logic [N-1:0] mult_clear;
  logic [N-1:0] lane_valid;
  logic         start;
  logic         tile_done;

  tile_skew_feeder_if #(.N(N), .W(W)) bus ();

  tile_skew_feeder #(.N(N), .W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .prod       (bus),
    .x_out      (x_out),
    .mult_clear (mult_clear),
    .lane_valid (lane_valid),
    .start      (start),
    .tile_done  (tile_done)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: c counts enabled cycles since the last reset; each
  // complete tile k remembers its rows and the cycle its row 0 is read.
  int             c = 0;
  bit             have_ref = 0;
  int             nt = 0;
  int             pcnt = 0;
  int             acc_total = 0;
  int             last_a = 0;
  logic [N*W-1:0] part [N];
  logic [N*W-1:0] trow [MAXT][N];
  int             ts [MAXT];

  bit             cap_on = 0;
  logic [W-1:0]   cap_x [64][N];
  logic [N-1:0]   cap_v [64];
  logic [N-1:0]   cap_c [64];
  logic           cap_d [64];

  typedef struct {
    int           lane;
    int           off;
    logic         vld;
    logic [W-1:0] val;
    logic         clr;
    logic         done;
  } vec_t;

  vec_t tbl [11];

  task automatic check1(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s c=%0d actual=%0h required=%0h", nm, c, act, exp);
    end
  endtask

  function automatic logic model_ready(input logic rst_v, input logic en_v);
    if (rst_v || !en_v) return 1'b0;
    if (nt >= 2 && c < ts[nt-2] + N) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [N*W-1:0] dirRow(input int t, input int rr);
    logic [N*W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*W +: W] = W'(1000 * t + 100 * rr + i);
    return v;
  endfunction

  // Compare every output against what the model says is on the lanes now.
  task automatic checkOutput();
    logic [W-1:0] ex [N];
    logic [N-1:0] ev, ec;
    logic         ed;
    int           rr;
    if (!have_ref) return;
    ev = '0; ec = '0; ed = 1'b0;
    for (int i = 0; i < N; i++) ex[i] = '0;
    for (int k = 0; k < nt; k++) begin
      for (int i = 0; i < N; i++) begin
        rr = c - ts[k] - 1 - i;
        if (rr >= 0 && rr < N) begin
          ex[i] = trow[k][rr][i*W +: W];
          ev[i] = 1'b1;
          ec[i] = (rr == 0);
          if (i == N - 1 && rr == N - 1) ed = 1'b1;
        end
      end
    end
    if (cap_on && c < 64) begin
      for (int i = 0; i < N; i++) cap_x[c][i] = x_out[i];
      cap_v[c] = lane_valid;
      cap_c[c] = mult_clear;
      cap_d[c] = tile_done;
    end
    check1("lane_valid", W'(lane_valid), W'(ev));
    check1("mult_clear", W'(mult_clear), W'(ec));
    check1("start", W'(start), W'(|ev));
    check1("tile_done", W'(tile_done), W'(ed));
    for (int i = 0; i < N; i++) check1($sformatf("x_out[%0d]", i), x_out[i], ex[i]);
  endtask

  task automatic modelStep(input logic rst_v, input logic en_v, input logic acc,
                           input logic [N*W-1:0] row_v);
    if (rst_v) begin
      c = 0; nt = 0; pcnt = 0; acc_total = 0; have_ref = 1;
    end else if (en_v) begin
      if (acc) begin
        part[pcnt] = row_v;
        pcnt++;
        acc_total++;
        if (pcnt == N) begin
          if (nt < MAXT) begin
            for (int rr = 0; rr < N; rr++) trow[nt][rr] = part[rr];
            ts[nt] = (nt == 0) ? c + 1 : ((c + 1 > ts[nt-1] + N) ? c + 1 : ts[nt-1] + N);
            nt++;
          end
          last_a = c;
          pcnt = 0;
        end
      end
      c++;
    end
  endtask

  // One clock cycle: check outputs, drive inputs, check in_ready, advance model.
  task automatic applyStimulus(input logic rst_v, input logic en_v, input logic vld_v,
                               input logic [N*W-1:0] row_v);
    logic exp_rdy;
    @(negedge clk);
    checkOutput();
    reset        = rst_v;
    enable       = en_v;
    bus.in_valid = vld_v;
    bus.in_row   = row_v;
    #1;
    exp_rdy = model_ready(rst_v, en_v);
    if (have_ref) check1("in_ready", W'(bus.in_ready), W'(exp_rdy));
    @(posedge clk);
    modelStep(rst_v, en_v, vld_v && exp_rdy, row_v);
  endtask

  // Feed ntile directed tiles, a row offered every gap cycles, with an
  // optional 5-cycle enable drop, then idle for tail cycles.
  task automatic runFeed(input int ntile, input int gap, input int stall_at, input int tail);
    int   idle;
    bit   ok;
    bit   fed;
    logic en_v, vld_v;
    idle = 0;
    ok   = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      fed = (acc_total >= ntile * N);
      if (fed) begin
        if (idle >= tail) begin
          ok = 1;
          break;
        end
        idle++;
      end
      en_v  = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 5);
      vld_v = !fed && (cyc % gap == 0);
      applyStimulus(1'b0, en_v, vld_v, vld_v ? dirRow(acc_total / N, acc_total % N) : '0);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL feed_timeout accepted=%0d required=%0d", acc_total, ntile * N);
    end
  endtask

  task automatic clearCapture();
    for (int k = 0; k < 64; k++) begin
      for (int i = 0; i < N; i++) cap_x[k][i] = '0;
      cap_v[k] = '0;
      cap_c[k] = '0;
      cap_d[k] = 1'b0;
    end
  endtask

  // Single-tile expectations relative to the cycle of the last accepted row.
  task automatic compareTable(input string tag);
    int cc;
    for (int e = 0; e < 11; e++) begin
      cc = last_a + tbl[e].off;
      if (cc >= 64) begin
        checks++; errors++;
        $display("[TB] FAIL %s_range entry=%0d cycle=%0d", tag, e, cc);
      end else begin
        check1($sformatf("%s_x%0d_off%0d", tag, tbl[e].lane, tbl[e].off),
               cap_x[cc][tbl[e].lane], tbl[e].val);
        check1($sformatf("%s_vld%0d_off%0d", tag, tbl[e].lane, tbl[e].off),
               W'(cap_v[cc][tbl[e].lane]), W'(tbl[e].vld));
        check1($sformatf("%s_clr%0d_off%0d", tag, tbl[e].lane, tbl[e].off),
               W'(cap_c[cc][tbl[e].lane]), W'(tbl[e].clr));
        check1($sformatf("%s_done_off%0d", tag, tbl[e].off),
               W'(cap_d[cc]), W'(tbl[e].done));
      end
    end
  endtask

  initial begin
    logic [N*W-1:0] rrow;
    logic           rst_v, en_v, vld_v;
    bit             seen;

    tbl[0]  = '{0,  1, 1'b0, 32'd0,   1'b0, 1'b0};
    tbl[1]  = '{0,  2, 1'b1, 32'd0,   1'b1, 1'b0};
    tbl[2]  = '{1,  3, 1'b1, 32'd1,   1'b1, 1'b0};
    tbl[3]  = '{0,  3, 1'b1, 32'd100, 1'b0, 1'b0};
    tbl[4]  = '{7,  9, 1'b1, 32'd7,   1'b1, 1'b0};
    tbl[5]  = '{3,  9, 1'b1, 32'd403, 1'b0, 1'b0};
    tbl[6]  = '{0,  9, 1'b1, 32'd700, 1'b0, 1'b0};
    tbl[7]  = '{5,  9, 1'b1, 32'd205, 1'b0, 1'b0};
    tbl[8]  = '{2, 10, 1'b1, 32'd602, 1'b0, 1'b0};
    tbl[9]  = '{0, 10, 1'b0, 32'd0,   1'b0, 1'b0};
    tbl[10] = '{7, 16, 1'b1, 32'd707, 1'b0, 1'b1};

    reset        = 1'b1;
    enable       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_row   = '0;

    $display("[TB] T1 reset");
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0);

    $display("[TB] T2 single tile");
    clearCapture();
    cap_on = 1;
    runFeed(1, 1, -1, 24);
    cap_on = 0;
    compareTable("t2");

    $display("[TB] T5 enable stall mid-stream");
    for (int k = 0; k < 2; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0);
    clearCapture();
    cap_on = 1;
    runFeed(1, 1, 12, 28);
    cap_on = 0;
    compareTable("t5");

    $display("[TB] T3 three tiles back-to-back");
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    runFeed(3, 1, -1, 30);

    $display("[TB] T4 bubbly input");
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    runFeed(2, 3, -1, 24);

    $display("[TB] T6 reset while streaming");
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    runFeed(1, 1, -1, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      #2;
      if (lane_valid[3]) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL t6_wait_lane3 actual=0 required=1");
    end
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    #2;
    check1("t6_lane_valid", W'(lane_valid), '0);
    check1("t6_start", W'(start), '0);
    clearCapture();
    cap_on = 1;
    runFeed(1, 1, -1, 24);
    cap_on = 0;
    compareTable("t6");

    $display("[TB] random traffic");
    for (int k = 0; k < 2000; k++) begin
      rst_v = ($urandom_range(0, 399) == 0);
      en_v  = ($urandom_range(0, 9) != 0);
      vld_v = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++) rrow[i*W +: W] = $urandom;
      applyStimulus(rst_v, en_v, vld_v, rrow);
    end
    for (int k = 0; k < 3 * N; k++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
